// File: rtl/spi_flash_target.sv
// SPI mode-3 target emulating the READ (0x03) path of a serial NOR flash.
// Fetches bytes through a byte-wide memory port with one-byte prefetch.
//
// state  | meaning
// IDLE   | chip-select released, waiting for cs low
// CMD    | shifting in the 8-bit command byte
// ADDR   | shifting in the 24-bit start address
// DATA   | streaming fetched bytes out on miso, auto-incrementing address
// IGNORE | unsupported command, wait for cs release with miso low
`timescale 1ns/1ps

module spi_flash_target (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  logic cs_s1_q, cs_s2_q;
  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic mosi_s1_q, mosi_s2_q;
  logic sclk_rise, sclk_fall;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        req_q, req_d;
  logic        und_q, und_d;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  logic [7:0]  cmd_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
    end else begin
      cs_s1_q     <= spi_cs;
      cs_s2_q     <= cs_s1_q;
      sclk_s1_q   <= spi_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      mosi_s1_q   <= spi_mosi;
      mosi_s2_q   <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
  assign cmd_next  = {cmd_q[6:0], mosi_s2_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      cmd_q      <= 8'h00;
      addr_q     <= 24'h000000;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      req_q      <= 1'b0;
      und_q      <= 1'b0;
      hold_q     <= 8'h00;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      req_q      <= req_d;
      und_q      <= und_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    req_d      = 1'b0;
    und_d      = 1'b0;
    hold_d     = hold_q;
    full_d     = full_q;

    // Responses are only meaningful while streaming; late ones in IDLE are dropped.
    if (state_q == DATA && mem_valid) begin
      hold_d = mem_rdata;
      full_d = 1'b1;
    end

    if (cs_s2_q) begin
      if (state_q != IDLE) begin
        state_d    = IDLE;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 2'd0;
        full_d     = 1'b0;
        miso_d     = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = CMD;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 2'd0;
          cmd_d      = 8'h00;
          miso_d     = 1'b0;
          full_d     = 1'b0;
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_d     = cmd_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7)
              state_d = (cmd_next == 8'h03) ? ADDR : IGNORE;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            addr_d    = {addr_q[22:0], mosi_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd2) begin
                state_d = DATA;
                req_d   = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (sclk_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
              tx_d   = full_q ? hold_q : 8'hFF;
              und_d  = ~full_q;
              miso_d = tx_d[7];
              full_d = 1'b0;
              addr_d = addr_q + 24'd1;
              req_d  = 1'b1;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              miso_d = tx_q[6];
            end
          end
        end
        IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign underrun = und_q;
  assign busy     = ~cs_s2_q;

endmodule

// File: tb/tb_spi_flash_target.sv
// Directed-plus-random bench for spi_flash_target: a mode-3 host, a latency
// programmable memory responder, and a flash READ reference model.
`timescale 1ns/1ps

module tb_spi_flash_target;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sclk = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_valid = 1'b0;
  logic        busy;
  logic        underrun;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int lat = 1;
  bit echo_mode = 1'b0;
  bit drop_en = 1'b0;
  int drop_at = 0;
  logic [7:0] lut [0:255];
  logic [7:0] ovr [int];
  int req_log [$];
  int pend_addr [$];
  int pend_due [$];
  int und_cnt = 0;
  int miso_hi = 0;
  logic [7:0] tx_buf [0:15];
  logic [7:0] rx_buf [0:15];

  spi_flash_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_of(input int a);
    logic [23:0] aa;
    aa = a[23:0];
    if (ovr.exists(a)) return ovr[a];
    if (echo_mode) return aa[7:0];
    return lut[aa[7:0]] ^ aa[15:8] ^ aa[23:16];
  endfunction

  // Memory responder and output monitors, all sampled mid-cycle.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (!reset_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mem_valid = 1'b1;
        mem_rdata = mem_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (mem_req === 1'b1) begin
        if (!(drop_en && req_log.size() == drop_at)) begin
          pend_addr.push_back(int'(mem_addr));
          pend_due.push_back(cyc + lat);
        end
        req_log.push_back(int'(mem_addr));
      end
    end
    if (underrun === 1'b1) und_cnt = und_cnt + 1;
    if (spi_miso === 1'b1) miso_hi = miso_hi + 1;
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Mode-3 host: mosi changes on the fall, miso is sampled just before the rise.
  task automatic spi_run(input int nbits, input int rst_bit);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      spi_sclk = 1'b0;
      spi_mosi = tx_buf[b / 8][7 - (b % 8)];
      if (b == rst_bit) begin
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_addr", {8'd0, mem_addr}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_und", {31'd0, underrun}, 32'd0);
        spi_cs = 1'b1;
        spi_sclk = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      rx_buf[b / 8][7 - (b % 8)] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    spi_cs = 1'b1;
    @(negedge clk);
    check("busy_hold", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_drop", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
  endtask

  // Reference: READ of n bytes from a returns mem[a+i] (0xFF for a withheld
  // first byte) and requests a, a+1, ..., a+n, wrapping at 24 bits.
  task automatic do_read(input logic [23:0] a, input int n, input int latency,
                         input bit withhold, input string tag);
    int base;
    int u0;
    logic [23:0] ai;
    logic [7:0] exp_b;
    int obs_a;
    tx_buf[0] = 8'h03;
    tx_buf[1] = a[23:16];
    tx_buf[2] = a[15:8];
    tx_buf[3] = a[7:0];
    for (int i = 0; i < n; i++) tx_buf[4 + i] = 8'($urandom);
    lat = latency;
    base = req_log.size();
    u0 = und_cnt;
    drop_at = base;
    drop_en = withhold;
    spi_run(32 + 8 * n, -1);
    drop_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      ai = a + 24'(i);
      exp_b = (withhold && i == 0) ? 8'hFF : mem_of(int'(ai));
      check($sformatf("%s_rx%0d", tag, i), {24'd0, rx_buf[4 + i]}, {24'd0, exp_b});
    end
    check($sformatf("%s_nreq", tag), req_log.size() - base, n + 1);
    for (int i = 0; i <= n; i++) begin
      ai = a + 24'(i);
      obs_a = (base + i < req_log.size()) ? req_log[base + i] : -1;
      check($sformatf("%s_req%0d", tag, i), obs_a, {8'd0, ai});
    end
    check($sformatf("%s_und", tag), und_cnt - u0, withhold ? 1 : 0);
  endtask

  initial begin
    int base;
    int m0;
    logic [7:0] acc;
    logic [23:0] ra;

    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_und", {31'd0, underrun}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    ovr[32'h100000] = 8'h12;
    ovr[32'h100001] = 8'h34;
    do_read(24'h100000, 2, 1, 1'b0, "rd100000");

    echo_mode = 1'b1;
    do_read(24'hFFFFFF, 3, 1, 1'b0, "rdwrap");
    echo_mode = 1'b0;

    tx_buf[0] = 8'h0B;
    for (int i = 1; i < 5; i++) tx_buf[i] = 8'($urandom);
    base = req_log.size();
    m0 = miso_hi;
    spi_run(40, -1);
    check("fast_nreq", req_log.size() - base, 0);
    check("fast_miso_hi", miso_hi - m0, 0);
    acc = rx_buf[1] | rx_buf[2] | rx_buf[3] | rx_buf[4];
    check("fast_rx", {24'd0, acc}, 32'd0);

    do_read(24'($urandom), 2, 2, 1'b1, "withhold");

    tx_buf[0] = 8'h03;
    tx_buf[1] = 8'h00;
    tx_buf[2] = 8'h00;
    base = req_log.size();
    spi_run(20, -1);
    check("abort_nreq", req_log.size() - base, 0);
    do_read(24'h000010, 2, 1, 1'b0, "rd000010");

    ra = 24'($urandom);
    tx_buf[0] = 8'h03;
    tx_buf[1] = ra[23:16];
    tx_buf[2] = ra[15:8];
    tx_buf[3] = ra[7:0];
    spi_run(48, 35);
    do_read(24'($urandom), 2, 1, 1'b0, "postrst");

    for (int k = 0; k < 6; k++) begin
      ra = (k % 2 == 1) ? (24'hFFFFFF - 24'($urandom_range(0, 2))) : 24'($urandom);
      do_read(ra, $urandom_range(1, 4), $urandom_range(1, 3), (k == 3),
              $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
